cmos_pixel_packer: RTL and testbench

//  Camera-side producer for the DDR3 frame-buffer write port. Captures 8-bit DVP sensor bytes on
//  cam_pclk, pairs them into 16-bit RGB565 pixels, and drives wr_vsync/wr_en/img_wr_data into ddr3_top.

---
 rtl/cam_pkg.sv | 19 +
 rtl/sync_2ff.sv | 21 ++
 rtl/cmos_pixel_packer.sv | 141 ++++++++++++++
 tb/tb_cmos_pixel_packer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and defaults for the DVP camera capture path
package cam_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int DEF_WAIT_FRAMES = 10;
  localparam int DEF_H_PIXELS    = 640;
  localparam int DEF_V_LINES     = 480;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser, async reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmos_pixel_packer.sv
// rtl/cmos_pixel_packer.sv - DVP byte pairing into RGB565 pixels with settle, frame gating and geometry check
module cmos_pixel_packer
  import cam_pkg::*;
#(
  parameter int WAIT_FRAMES = DEF_WAIT_FRAMES,
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        transfer_flag,
  output logic        wr_vsync,
  output logic        wr_en,
  output logic [15:0] img_wr_data,
  output logic        frame_err
);

  localparam int SET_W  = cnt_w(WAIT_FRAMES);
  localparam int PIX_W  = cnt_w(H_PIXELS);
  localparam int LINE_W = cnt_w(V_LINES);

  logic       vsync_d0, vsync_d1, href_d0, href_d1;
  logic [7:0] data_d0;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
      data_d0  <= 8'h00;
    end else begin
      vsync_d0 <= cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= cam_href;
      href_d1  <= href_d0;
      data_d0  <= cam_data;
    end
  end

  logic vs_rise, href_fall, pair_act;
  assign vs_rise   = vsync_d0 & ~vsync_d1;
  assign href_fall = href_d1 & ~href_d0;
  assign pair_act  = href_d0 & ~vsync_d0;

  logic             flag_sync;
  logic [SET_W-1:0] settle_cnt;
  logic             frame_val, frame_en;

  sync_2ff u_flag_sync (
    .clk   (cam_pclk),
    .rst_n (rst_n),
    .d     (transfer_flag),
    .q     (flag_sync)
  );

  assign frame_val = (settle_cnt == SET_W'(WAIT_FRAMES));
  assign wr_vsync  = vsync_d1 & frame_val;

  // Frame gating only changes at a frame boundary so frames are never cut.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      frame_en   <= 1'b0;
    end else if (vs_rise) begin
      frame_en <= flag_sync;
      if (!frame_val) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  logic    phase;
  logic [7:0] hi;
  rgb565_t pix_q;

  assign img_wr_data = pix_q;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi    <= 8'h00;
      pix_q <= '0;
      wr_en <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (pair_act) begin
        phase <= ~phase;
        if (!phase) begin
          hi <= data_d0;
        end else begin
          pix_q <= {hi, data_d0};
          wr_en <= frame_val & frame_en;
        end
      end else if (!href_d0) begin
        phase <= 1'b0;
      end
    end
  end

  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt, line_cnt_upd;
  logic              line_bad, line_bad_upd;

  // A line ending on the same cycle as vs_rise is folded in before the frame check.
  always_comb begin
    line_cnt_upd = line_cnt;
    line_bad_upd = line_bad;
    if (href_fall) begin
      if (!(&line_cnt)) line_cnt_upd = line_cnt + 1'b1;
      if ((pix_cnt != PIX_W'(H_PIXELS)) || phase) line_bad_upd = 1'b1;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt   <= '0;
      line_cnt  <= '0;
      line_bad  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (href_fall) begin
        pix_cnt <= '0;
      end else if (pair_act && phase && !(&pix_cnt)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (vs_rise) begin
        frame_err <= frame_en & frame_val &
                     (line_bad_upd | (line_cnt_upd != LINE_W'(V_LINES)));
        line_cnt  <= '0;
        line_bad  <= 1'b0;
      end else begin
        line_cnt <= line_cnt_upd;
        line_bad <= line_bad_upd;
      end
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// tb/tb_cmos_pixel_packer.sv - scoreboard bench for cmos_pixel_packer
module tb_cmos_pixel_packer;

  localparam int WF = 2;
  localparam int HP = 4;
  localparam int VL = 2;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        transfer_flag = 1'b0;
  logic        wr_vsync, wr_en, frame_err;
  logic [15:0] img_wr_data;

  cmos_pixel_packer #(.WAIT_FRAMES(WF), .H_PIXELS(HP), .V_LINES(VL)) dut (
    .cam_pclk      (cam_pclk),
    .rst_n         (rst_n),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .transfer_flag (transfer_flag),
    .wr_vsync      (wr_vsync),
    .wr_en         (wr_en),
    .img_wr_data   (img_wr_data),
    .frame_err     (frame_err)
  );

  always #5 cam_pclk = ~cam_pclk;

  int cyc = 0;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         vs_rises = 0;
  int         pulse_idx = 0;
  logic       fe_prev = 1'b0;
  logic       vs_prev = 1'b0;
  logic [7:0] line_buf[16];

  always @(negedge cam_pclk) begin
    exp_t e;
    if (rst_n) begin
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr_en: got data %h at cycle %0d, required no pixel", img_wr_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (img_wr_data !== e.data || cyc != e.at) begin
            errors++;
            $display("FAIL pixel: got %h at cycle %0d, required %h at cycle %0d", img_wr_data, cyc, e.data, e.at);
          end
        end
      end
      if (frame_err) begin
        err_pulses++;
        checks++;
        if (fe_prev) begin
          errors++;
          $display("FAIL frame_err_width: got high 2+ cycles, required 1-cycle pulse");
        end
      end
      if (wr_vsync && !vs_prev) vs_rises++;
    end
    fe_prev = frame_err;
    vs_prev = wr_vsync;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic fill_ramp(input logic [7:0] base);
    for (int i = 0; i < 16; i++) line_buf[i] = base + 8'(i);
  endtask

  task automatic send_line(input int n, input int off, input bit stream);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = line_buf[off + i];
      if (stream && i[0]) begin
        e.data = {line_buf[off + i - 1], line_buf[off + i]};
        e.at   = cyc + 2;
        exp_q.push_back(e);
      end
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge cam_pclk);
  endtask

  task automatic frame_end(input bit stream, input bit bad);
    int e0, v0;
    e0 = err_pulses;
    v0 = vs_rises;
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge cam_pclk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge cam_pclk);
    pulse_idx++;
    chk("wr_vsync_pulses", vs_rises - v0, (pulse_idx >= WF) ? 1 : 0);
    chk("frame_err_pulses", err_pulses - e0, (stream && bad) ? 1 : 0);
    chk("pending_pixels", exp_q.size(), 0);
  endtask

  task automatic std_frame(input int lines, input int first_len, input bit stream, input bit bad);
    fill_ramp(8'h00);
    for (int l = 0; l < lines; l++) send_line((l == 0) ? first_len : 8, (l % 2) * 8, stream);
    frame_end(stream, bad);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_vsync"}, wr_vsync, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_img_wr_data"}, img_wr_data, 0);
  endtask

  initial begin
    transfer_flag = 1'b1;
    repeat (3) @(negedge cam_pclk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge cam_pclk);

    // Settle frames 0-1 suppressed; frame 2 streams.
    std_frame(2, 8, 1'b0, 1'b0);
    std_frame(2, 8, 1'b0, 1'b0);
    std_frame(2, 8, 1'b1, 1'b0);

    // Flag drops mid frame 3: frame 3 completes, 4 and 5 halted, 6 streams.
    fill_ramp(8'h00);
    send_line(8, 0, 1'b1);
    transfer_flag = 1'b0;
    send_line(8, 8, 1'b1);
    frame_end(1'b1, 1'b0);
    std_frame(2, 8, 1'b0, 1'b0);
    fill_ramp(8'h00);
    send_line(8, 0, 1'b0);
    transfer_flag = 1'b1;
    send_line(8, 8, 1'b0);
    frame_end(1'b0, 1'b0);
    std_frame(2, 8, 1'b1, 1'b0);

    // Odd byte line, then too many lines, then a clean frame.
    std_frame(2, 7, 1'b1, 1'b1);
    std_frame(3, 8, 1'b1, 1'b1);
    std_frame(2, 8, 1'b1, 1'b0);

    // AB,CD pairing and exact latency.
    fill_ramp(8'h00);
    line_buf[0] = 8'hAB; line_buf[1] = 8'hCD; line_buf[2] = 8'h11; line_buf[3] = 8'h22;
    line_buf[4] = 8'h33; line_buf[5] = 8'h44; line_buf[6] = 8'h55; line_buf[7] = 8'h66;
    send_line(8, 0, 1'b1);
    send_line(8, 8, 1'b1);
    frame_end(1'b1, 1'b0);

    // Reset mid-line in a streaming frame.
    fill_ramp(8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = line_buf[i];
      if (i == 1 || i == 3) exp_q.push_back('{data: {line_buf[i - 1], line_buf[i]}, at: cyc + 2});
    end
    @(negedge cam_pclk);
    chk("pre_reset_wr_en", wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    exp_q.delete();
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge cam_pclk);
    rst_n = 1'b1;
    pulse_idx = 0;
    std_frame(2, 8, 1'b0, 1'b0);
    std_frame(2, 8, 1'b0, 1'b0);
    std_frame(2, 8, 1'b1, 1'b0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
